// File: rtl/fp_normalizer.sv
// fp_normalizer: normalize / round-to-nearest-even / pack stage that follows
// the significand adder of a single-precision FP adder/subtractor.
//
// mant_in layout (MAN_W+4 bits): [carry | hidden | fraction | guard | sticky]
//
// Optional build macro FP_NORM_FAST_EN: when defined, NORM resolves in one
// cycle with a leading-zero count and barrel shift (constant 2-cycle latency).
// When undefined, NORM shifts left one bit per cycle. Results and flags are
// identical in both builds.
module fp_normalizer #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sign_in,
  input  logic [EXP_W-1:0]       exp_in,
  input  logic [MAN_W+3:0]       mant_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   flag_ovf,
  output logic                   flag_unf,
  output logic                   flag_inexact
);

  localparam int MW     = MAN_W + 4;   // significand register width
  localparam int XW     = EXP_W + 1;   // extra exponent bit exposes overflow
  localparam int CARRY  = MAN_W + 3;
  localparam int HIDDEN = MAN_W + 2;

  localparam logic [XW-1:0] EXP_ONE = XW'(1);
  localparam logic [XW-1:0] EXP_INF = {1'b0, {EXP_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t        state;
  logic          sign_r;
  logic [XW-1:0] exp_r;
  logic [MW-1:0] mant_r;

  // One-bit shifts used by NORM. A right shift folds the bit leaving the
  // sticky position back into sticky; a left shift moves sticky into guard.
  logic [MW-1:0] mant_rsh;
  logic [MW-1:0] mant_lsh;

  assign mant_rsh = {1'b0, mant_r[MW-1:2], mant_r[1] | mant_r[0]};
  assign mant_lsh = {mant_r[MW-2:0], 1'b0};

  // Round-to-nearest-even on the normalized significand in mant_r.
  logic             rnd_guard;
  logic             rnd_sticky;
  logic             rnd_inc;
  logic [MAN_W+1:0] rnd_sum;    // {carry-out, hidden, fraction}
  logic             rnd_co;
  logic [MAN_W-1:0] rnd_frac;
  logic [XW-1:0]    rnd_exp;
  logic             rnd_ovf;

  assign rnd_guard  = mant_r[1];
  assign rnd_sticky = mant_r[0];
  assign rnd_inc    = rnd_guard & (rnd_sticky | mant_r[2]);
  assign rnd_sum    = {1'b0, mant_r[HIDDEN:2]} + {{(MAN_W+1){1'b0}}, rnd_inc};
  assign rnd_co     = rnd_sum[MAN_W+1];
  // A carry out of the hidden bit leaves 10.000..0, so the shifted fraction
  // is simply the upper bits of the sum.
  assign rnd_frac   = rnd_co ? rnd_sum[MAN_W:1] : rnd_sum[MAN_W-1:0];
  assign rnd_exp    = exp_r + {{EXP_W{1'b0}}, rnd_co};
  assign rnd_ovf    = (rnd_exp >= EXP_INF);

`ifdef FP_NORM_FAST_EN
  // Leading zeros counted from the hidden bit downwards.
  logic [XW-1:0] lzc;
  logic          lz_found;
  logic          flush_r;   // underflow decided in NORM, reported in ROUND

  // Leading-zero counter over hidden..sticky.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    lzc      = '0;
    lz_found = 1'b0;
    for (int i = HIDDEN; i >= 0; i--) begin
      if (!lz_found) begin
        if (mant_r[i]) lz_found = 1'b1;
        else           lzc      = lzc + EXP_ONE;
      end
    end
  end
`endif

  // Control FSM with registered handshake outputs, result and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments throughout so every register samples
      // pre-edge values regardless of statement order.
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      result       <= '0;
      flag_ovf     <= 1'b0;
      flag_unf     <= 1'b0;
      flag_inexact <= 1'b0;
      sign_r       <= 1'b0;
      exp_r        <= '0;
      mant_r       <= '0;
`ifdef FP_NORM_FAST_EN
      flush_r      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sign_r   <= sign_in;
            exp_r    <= {1'b0, exp_in};
            mant_r   <= mant_in;
            in_ready <= 1'b0;
            state    <= NORM;
`ifdef FP_NORM_FAST_EN
            flush_r  <= 1'b0;
`endif
          end
        end

        NORM: begin
`ifdef FP_NORM_FAST_EN
          // Single-cycle resolution; zero and flush also pass through ROUND
          // so latency is the same for every operand.
          state <= ROUND;
          if (mant_r[CARRY]) begin
            mant_r <= mant_rsh;
            exp_r  <= exp_r + EXP_ONE;
          end else if (mant_r[HIDDEN]) begin
            // already normalized
          end else if (mant_r == '0) begin
            sign_r <= 1'b0;
            exp_r  <= '0;
          end else if (exp_r <= lzc) begin
            // shift limited by the exponent: the value cannot be normalized
            flush_r <= 1'b1;
          end else begin
            mant_r <= mant_r << lzc;
            exp_r  <= exp_r - lzc;
          end
`else
          // One step per cycle: right shift on carry, left shift otherwise.
          if (mant_r[CARRY]) begin
            mant_r <= mant_rsh;
            exp_r  <= exp_r + EXP_ONE;
            state  <= ROUND;
          end else if (mant_r[HIDDEN]) begin
            state <= ROUND;
          end else if (mant_r == '0) begin
            result       <= '0;
            flag_ovf     <= 1'b0;
            flag_unf     <= 1'b0;
            flag_inexact <= 1'b0;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else if (exp_r <= EXP_ONE) begin
            result       <= {sign_r, {(EXP_W+MAN_W){1'b0}}};
            flag_ovf     <= 1'b0;
            flag_unf     <= 1'b1;
            flag_inexact <= 1'b1;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else begin
            mant_r <= mant_lsh;
            exp_r  <= exp_r - EXP_ONE;
          end
`endif
        end

        ROUND: begin
`ifdef FP_NORM_FAST_EN
          if (flush_r) begin
            result       <= {sign_r, {(EXP_W+MAN_W){1'b0}}};
            flag_ovf     <= 1'b0;
            flag_unf     <= 1'b1;
            flag_inexact <= 1'b1;
          end else
`endif
          if (rnd_ovf) begin
            result       <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flag_ovf     <= 1'b1;
            flag_unf     <= 1'b0;
            flag_inexact <= 1'b1;
          end else begin
            result       <= {sign_r, rnd_exp[EXP_W-1:0], rnd_frac};
            flag_ovf     <= 1'b0;
            flag_unf     <= 1'b0;
            flag_inexact <= rnd_guard | rnd_sticky;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed testbench for fp_normalizer (default parameters, single precision).
// Expected results are hand-computed IEEE-754 encodings.
module tb_fp_normalizer;

`ifdef FP_NORM_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign_in = 1'b0;
  logic [7:0]  exp_in = '0;
  logic [26:0] mant_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        flag_ovf;
  logic        flag_unf;
  logic        flag_inexact;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       name;
    logic        s;
    logic [7:0]  e;
    logic [26:0] m;
    logic [31:0] res;
    logic [2:0]  fl;    // {ovf, unf, inexact}
    int          lat;   // iterative-build latency
  } vec_t;

  fp_normalizer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sign_in      (sign_in),
    .exp_in       (exp_in),
    .mant_in      (mant_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .flag_ovf     (flag_ovf),
    .flag_unf     (flag_unf),
    .flag_inexact (flag_inexact)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic s, logic [7:0] e, logic [26:0] m,
                              logic [31:0] r, logic [2:0] f, int l);
    vec_t v;
    v.name = n; v.s = s; v.e = e; v.m = m; v.res = r; v.fl = f;
    v.lat  = FAST ? 2 : l;
    return v;
  endfunction

  // Present one operand for a single accept edge.
  task automatic start_op(input logic s, input logic [7:0] e, input logic [26:0] m);
    @(negedge clk);
    sign_in  = s;
    exp_in   = e;
    mant_in  = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid; -1 if the bound expires.
  task automatic wait_valid(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      if (out_valid) begin
        lat = i - 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (lat < 0 && out_valid) lat = budget;
  endtask

  // Drive, capture, and (with out_ready high) let the transfer happen.
  task automatic do_op(input vec_t v, output logic [31:0] res,
                       output logic [2:0] fl, output int lat);
    start_op(v.s, v.e, v.m);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    res = result;
    fl  = {flag_ovf, flag_unf, flag_inexact};
    if (lat > 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_handshake: in_ready,out_valid=%b want 10", {in_ready, out_valid});
    end
    vectors++;
    if ({result, flag_ovf, flag_unf, flag_inexact} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: result=%h flags=%b want 0", result,
               {flag_ovf, flag_unf, flag_inexact});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_carry;
    vec_t vs[3];
    logic [31:0] r;
    logic [2:0]  f;
    int          l;
    vs[0] = mk("carry_1p5_plus_1p5", 1'b0, 8'd127, 27'h6000000, 32'h40400000, 3'b000, 2);
    vs[1] = mk("carry_3p5",          1'b0, 8'd127, 27'h7000000, 32'h40600000, 3'b000, 2);
    vs[2] = mk("hidden_only_1p0",    1'b0, 8'd127, 27'h2000000, 32'h3F800000, 3'b000, 2);
    foreach (vs[i]) begin
      do_op(vs[i], r, f, l);
      vectors++;
      if (r !== vs[i].res) begin
        miscompares++;
        $display("FAIL %s result: got %h want %h", vs[i].name, r, vs[i].res);
      end
      vectors++;
      if (f !== vs[i].fl) begin
        miscompares++;
        $display("FAIL %s flags: got %b want %b", vs[i].name, f, vs[i].fl);
      end
      vectors++;
      if (l !== vs[i].lat) begin
        miscompares++;
        $display("FAIL %s latency: got %0d want %0d", vs[i].name, l, vs[i].lat);
      end
    end
  endtask

  task automatic test_left_shift;
    vec_t vs[2];
    logic [31:0] r;
    logic [2:0]  f;
    int          l;
    // only fraction LSB: 23 left shifts, exponent 130 -> 107
    vs[0] = mk("cancellation",   1'b0, 8'd130, 27'h0000004, 32'h35800000, 3'b000, 25);
    // frac MSB + guard + sticky: one shift puts sticky in guard, RNE rounds up
    vs[1] = mk("shift1_sticky",  1'b0, 8'd127, 27'h1000003, 32'h3F000002, 3'b001, 3);
    foreach (vs[i]) begin
      do_op(vs[i], r, f, l);
      vectors++;
      if (r !== vs[i].res) begin
        miscompares++;
        $display("FAIL %s result: got %h want %h", vs[i].name, r, vs[i].res);
      end
      vectors++;
      if (f !== vs[i].fl) begin
        miscompares++;
        $display("FAIL %s flags: got %b want %b", vs[i].name, f, vs[i].fl);
      end
      vectors++;
      if (l !== vs[i].lat) begin
        miscompares++;
        $display("FAIL %s latency: got %0d want %0d", vs[i].name, l, vs[i].lat);
      end
    end
  endtask

  task automatic test_round_overflow;
    vec_t vs[4];
    logic [31:0] r;
    logic [2:0]  f;
    int          l;
    vs[0] = mk("rne_carry_out",   1'b0, 8'd127, 27'h3FFFFFE, 32'h40000000, 3'b001, 2);
    // carry shift moves frac LSB into guard; tie with even LSB keeps value
    vs[1] = mk("tie_even_keep",   1'b0, 8'd127, 27'h6000004, 32'h40400000, 3'b001, 2);
    // same, but the sticky bit shifted out is kept, so it rounds up
    vs[2] = mk("rsh_sticky_up",   1'b0, 8'd127, 27'h6000005, 32'h40400001, 3'b001, 2);
    vs[3] = mk("overflow_neg",    1'b1, 8'd254, 27'h4000000, 32'hFF800000, 3'b101, 2);
    foreach (vs[i]) begin
      do_op(vs[i], r, f, l);
      vectors++;
      if (r !== vs[i].res) begin
        miscompares++;
        $display("FAIL %s result: got %h want %h", vs[i].name, r, vs[i].res);
      end
      vectors++;
      if (f !== vs[i].fl) begin
        miscompares++;
        $display("FAIL %s flags: got %b want %b", vs[i].name, f, vs[i].fl);
      end
      vectors++;
      if (l !== vs[i].lat) begin
        miscompares++;
        $display("FAIL %s latency: got %0d want %0d", vs[i].name, l, vs[i].lat);
      end
    end
  endtask

  task automatic test_zero_underflow;
    vec_t vs[3];
    logic [31:0] r;
    logic [2:0]  f;
    int          l;
    vs[0] = mk("zero_neg_sign",   1'b1, 8'd100, 27'h0000000, 32'h00000000, 3'b000, 1);
    vs[1] = mk("unf_guard_only",  1'b0, 8'd1,   27'h0000002, 32'h00000000, 3'b011, 1);
    // two left shifts bring exp to 1 before hidden is reached
    vs[2] = mk("unf_after_shift", 1'b1, 8'd3,   27'h0000004, 32'h80000000, 3'b011, 3);
    foreach (vs[i]) begin
      do_op(vs[i], r, f, l);
      vectors++;
      if (r !== vs[i].res) begin
        miscompares++;
        $display("FAIL %s result: got %h want %h", vs[i].name, r, vs[i].res);
      end
      vectors++;
      if (f !== vs[i].fl) begin
        miscompares++;
        $display("FAIL %s flags: got %b want %b", vs[i].name, f, vs[i].fl);
      end
      vectors++;
      if (l !== vs[i].lat) begin
        miscompares++;
        $display("FAIL %s latency: got %0d want %0d", vs[i].name, l, vs[i].lat);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    out_ready = 1'b0;
    start_op(1'b0, 8'd127, 27'h6000000);
    wait_valid(60, lat);
    vectors++;
    if (lat !== 2) begin
      miscompares++;
      $display("FAIL bp_first_latency: got %0d want 2", lat);
    end
    // second operand offered while the first result is stalled
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      sign_in  = 1'b0;
      exp_in   = 8'd127;
      mant_in  = 27'h2000000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if ({out_valid, in_ready, result} !== {2'b10, 32'h40400000}) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b result=%h want 1 0 40400000",
                 c, out_valid, in_ready, result);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_transfer: out_valid,in_ready=%b want 01", {out_valid, in_ready});
    end
    // in_valid still high: second operand accepted on this edge
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_second_accept: in_ready=%b want 0", in_ready);
    end
    wait_valid(60, lat);
    vectors++;
    if (lat !== 2 || result !== 32'h3F800000) begin
      miscompares++;
      $display("FAIL bp_second_result: latency=%0d result=%h want 2 3F800000", lat, result);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort;
    logic [31:0] r;
    logic [2:0]  f;
    int          l;
    logic        seen;
    vec_t        v;
    start_op(1'b0, 8'd130, 27'h0000004);
    repeat (1) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL abort_immediate: out_valid,in_ready=%b want 01", {out_valid, in_ready});
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_output: out_valid seen=%b want 0", seen);
    end
    v = mk("after_abort", 1'b0, 8'd127, 27'h6000000, 32'h40400000, 3'b000, 2);
    do_op(v, r, f, l);
    vectors++;
    if ({r, f} !== {v.res, v.fl} || l !== v.lat) begin
      miscompares++;
      $display("FAIL after_abort: result=%h flags=%b latency=%0d want %h %b %0d",
               r, f, l, v.res, v.fl, v.lat);
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_left_shift();
    test_round_overflow();
    test_zero_underflow();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_normalizer.md
Name: fp_normalizer

Overview:
- Post-addition normalize/round/pack stage of the IEEE-754 single-precision adder/subtractor.
- The exponent comparator and alignment stage bring both operands to a common exponent. This block undoes that: it takes the raw significand sum with the common exponent, renormalizes it, rounds (RNE) and packs a 32-bit result.
- Iterative FSM with valid/ready handshakes on both sides.

Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, stored fraction width (hidden bit excluded)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand presented
- in_ready  output  1  block can accept operand
- sign_in  input  1  sign of the sum
- exp_in  input  EXP_W  common (larger) biased exponent
- mant_in  input  MAN_W+4  bit layout:
  - [MAN_W+3] carry
  - [MAN_W+2] hidden
  - [MAN_W+1:2] fraction
  - [1] guard
  - [0] sticky
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  1+EXP_W+MAN_W  packed {sign, exp, frac}
- flag_ovf  output  1  overflow to infinity
- flag_unf  output  1  underflow flushed to zero
- flag_inexact  output  1  guard or sticky nonzero before rounding, or flush of a nonzero value

Behaviour:
- Reset (async, rst=1):
  - State = IDLE.
  - in_ready=1, out_valid=0, result=0, all flags 0, internal registers 0.
  - Reset mid-operation aborts the operation; no partial output appears.
- Internal exponent register is EXP_W+1 bits wide so overflow is detectable.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch sign, exp, mant; go to NORM.
  - in_ready=0 in all other states.
- NORM (evaluated in this priority order each cycle):
  - Carry set: shift right 1 (shifted-out bit ORed into sticky), exp+1, go to ROUND.
  - Hidden set: go to ROUND.
  - mant==0: result = +0 (sign forced 0), go to DONE.
  - exp<=1: flush to signed zero, flag_unf=1, flag_inexact=1, go to DONE.
  - Otherwise: shift left 1 (sticky shifts into guard, 0 into sticky), exp-1, stay in NORM.
- ROUND:
  - Increment when guard && (sticky || frac_lsb).
  - If the increment carries out of the hidden bit: shift right 1, exp+1.
  - If exp >= 2^EXP_W-1: result = signed infinity (exp all ones, frac 0), flag_ovf=1, flag_inexact=1.
  - Otherwise pack {sign, exp[EXP_W-1:0], frac}.
  - flag_inexact = guard|sticky.
  - Go to DONE.
- DONE:
  - out_valid=1; result and flags held stable.
  - On out_ready: out_valid=0, go to IDLE. in_ready returns to 1 the cycle after the transfer.
- exp_in==0 with hidden=0: handled by the exp<=1 rule (denormals flushed).
- Latency from the accept edge to out_valid:
  - Carry or hidden case: 2 cycles.
  - Left shift of k positions: 2+k cycles.
  - Zero or underflow: 1+k cycles.
- Throughput is one operation in flight; no pipelining.

Optional Feature:
- Macro FP_NORM_FAST_EN.
- Defined: NORM resolves in one cycle using a leading-zero counter and barrel shift.
  - Shift amount = min(lzc, exp-1).
  - If the shift is limited by exp, the underflow flush applies.
  - Latency becomes a constant 2 cycles for every case.
- Undefined: iterative one-bit-per-cycle shift as described above.
- Results and flags are bit-identical in both builds; only latency differs.

Test Plan:
- 1.5+1.5: exp_in=127, mant_in=carry|hidden|frac MSB, out_ready=1 -> result=0x40400000, flags 0, out_valid 2 cycles after accept.
- Cancellation: exp_in=130, mant_in=only fraction LSB (bit 2) set -> result=0x35800000 after 23 left shifts, out_valid at cycle 25 (iterative) / 2 (FP_NORM_FAST_EN).
- Round tie-to-even carry-out: exp_in=127, hidden and all fraction bits set, guard=1, sticky=0 -> result=0x40000000, flag_inexact=1.
- Overflow: exp_in=254, sign_in=1, carry set -> result=0xFF800000, flag_ovf=1, flag_inexact=1.
- Zero/underflow: mant_in=0, sign_in=1 -> 0x00000000, no flags. exp_in=1, only the guard bit set -> 0x00000000, flag_unf=1.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles: result stable, in_ready=0, and a second in_valid is not accepted until after the transfer.
  - Assert rst while in NORM: out_valid=0 and in_ready=1 immediately; the next operand completes correctly.
